inv_mix_columns_seq: RTL and testbench
======================================

Name: inv_mix_columns_seq

Overview:
Sequential AES InvMixColumns engine for the decryption datapath. It accepts a 128-bit state through a valid/ready handshake and applies the inverse column transform to LANES columns per cycle, using LANES instances of a combinational inverse column unit. It returns the 128-bit result through a second valid/ready handshake. It is the decrypt-side counterpart of the existing forward column mixer and uses the same byte/column packing.

Parameters:
LANES, 1, columns transformed per cycle; legal values 1, 2, 4; ITERS = 4/LANES; any other value is an elaboration error.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_state is valid.
in_ready  output  1  block can accept a state.
in_state  input  128  column c = in_state[32c+31:32c]; byte r of a column = bits [8r+7:8r].
out_valid  output  1  out_state is valid.
out_ready  input  1  consumer accepts out_state.
out_state  output  128  transformed state, same packing as in_state.
busy  output  1  high in BUSY or DONE.

Behaviour:
- Per column, with bytes a0..a3: b0=14a0^11a1^13a2^9a3; b1=9a0^14a1^11a2^13a3; b2=13a0^9a1^14a2^11a3; b3=11a0^13a1^9a2^14a3.
- All products are GF(2^8) with reduction polynomial 0x11B. Every intermediate value is reduced to 8 bits before XOR; no 9/10-bit intermediates reach an output.
- FSM states are IDLE, BUSY and DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, load in_state into the working register, clear col_idx to 0 and go to BUSY.
- BUSY: each cycle, transform columns col_idx*LANES .. col_idx*LANES+LANES-1 in place, then increment col_idx. On the cycle that processes the last group (col_idx==ITERS-1), go to DONE.
- DONE: out_valid=1 and out_state = working register, held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- in_ready is 0 in BUSY and DONE. in_valid there is ignored and the upstream must hold its data.
- Latency: the accept edge plus ITERS edges, so out_valid rises ITERS cycles after the accept edge (4 for LANES=1, 1 for LANES=4).
- Throughput: one state per ITERS+2 cycles minimum; back-to-back accept in the same cycle as output handshake is not supported.
- If out_ready is already high when DONE is entered, the output handshake completes on the first DONE cycle.
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, out_state=0, col_idx=0, working register=0.
- Reset asserted mid-operation aborts immediately and asynchronously. The partial state is discarded and no out_valid is produced for it.
- out_state is driven only from the working register (registered output). It is not X-propagating from in_state when idle.
- col_idx is $clog2(ITERS)-wide with a minimum of 1 bit. It is never incremented past ITERS-1; no wrap occurs in BUSY.

Decomposition:
- aes_pkg holds:
  - constant AES_POLY=8'h1B;
  - function gf_xtime(8-bit) returning the reduced 8-bit product;
  - typedef aes_word_t = logic [3:0][7:0];
  - typedef aes_state_t = logic [3:0][31:0];
  - FSM enum imc_state_e {IDLE, BUSY, DONE}.
- Sub-module inv_mix_word is purely combinational: 32-bit in_word to 32-bit out_word, same packing. It builds x2/x4/x8 via gf_xtime chains and forms 9, 11, 13 and 14 by XOR. It is generated LANES times; the lane select is muxed from col_idx.

Test Plan:
- Load column 0 = 32'hbca14d8e and columns 1..3 = 32'h01010101, LANES=1 -> out_valid 4 cycles after the accept edge; out_state[31:0]=32'h455313db; columns 1..3 unchanged at 32'h01010101.
- in_state = {4{32'hd6d7d5d5}}, LANES=4 -> out_valid 1 cycle after the accept edge; out_state = {4{32'hd5d4d4d4}}.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and in_state -> out_state stable, in_ready=0, no new state accepted. Then out_ready=1 -> one transfer, return to IDLE with in_ready=1.
- Round trip: random states passed through the forward mixer, then this block, for LANES=1, 2 and 4, 1000 iterations -> output equals the original state each time.
- Assert rst for 1 cycle at BUSY col_idx=2 -> outputs immediately go to their reset values and no out_valid follows. The next load of 32'hbca14d8e in column 0 yields 32'h455313db.
- All-zero and all-0xFF states -> 0 maps to 0; {16{8'hff}} maps to {16{8'hff}}, since the coefficients 14^11^13^9 = 1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the column mixing datapath.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [3:0][7:0]  aes_word_t;
    typedef logic [3:0][31:0] aes_state_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} imc_state_e;

    // Multiply by x in GF(2^8), reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        gf_xtime = {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_word.sv
// Combinational InvMixColumns on one 32-bit column (byte r at bits [8r+7:8r]).
module inv_mix_word
    import aes_pkg::*;
(
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);

    aes_word_t a;
    aes_word_t b;
    aes_word_t x2, x4, x8;
    aes_word_t m9, m11, m13, m14;

    assign a        = in_word;
    assign out_word = b;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            x2[r]  = gf_xtime(a[r]);
            x4[r]  = gf_xtime(x2[r]);
            x8[r]  = gf_xtime(x4[r]);
            m9[r]  = x8[r] ^ a[r];
            m11[r] = x8[r] ^ x2[r] ^ a[r];
            m13[r] = x8[r] ^ x4[r] ^ a[r];
            m14[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        // Each output row is the 14/11/13/9 coefficient row rotated by r.
        for (int r = 0; r < 4; r++) begin
            b[r] = m14[r] ^ m11[(r + 1) % 4] ^ m13[(r + 2) % 4] ^ m9[(r + 3) % 4];
        end
    end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns engine: LANES columns per cycle, valid/ready on both sides.
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int ITERS = 4 / LANES;
    localparam int IDX_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("inv_mix_columns_seq: LANES must be 1, 2 or 4");
    end

    imc_state_e             state_q, state_d;
    aes_state_t             work_q, work_d;
    logic [IDX_W-1:0]       col_idx_q, col_idx_d;
    logic [LANES-1:0][31:0] lane_out;
    logic [1:0]             lane_col [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_col[l] = 2'(int'(col_idx_q) * LANES + l);

        inv_mix_word u_word (
            .in_word  (work_q[lane_col[l]]),
            .out_word (lane_out[l])
        );
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        col_idx_d = col_idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d    = in_state;
                    col_idx_d = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[lane_col[l]] = lane_out[l];
                end
                // Hold the index on the last group so it never wraps.
                if (col_idx_q == IDX_W'(ITERS - 1)) begin
                    state_d = DONE;
                end else begin
                    col_idx_d = col_idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            work_q    <= '0;
            col_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            col_idx_q <= col_idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Randomised self-checking bench for inv_mix_columns_seq at LANES = 1, 2 and 4.
module tb_inv_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic [127:0] in_state_a  [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] out_state_a [3];
    logic         busy_a      [3];

    int n_total = 0;
    int n_bad   = 0;

    inv_mix_columns_seq #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_state(in_state_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_state(out_state_a[0]),
        .busy(busy_a[0])
    );

    inv_mix_columns_seq #(.LANES(2)) u_l2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_state(in_state_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_state(out_state_a[1]),
        .busy(busy_a[1])
    );

    inv_mix_columns_seq #(.LANES(4)) u_l4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .in_state(in_state_a[2]),
        .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_state(out_state_a[2]),
        .busy(busy_a[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Polynomial multiply then reduce by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011B << (i - 8);
        return p[7:0];
    endfunction

    // Column mix with circulant matrix whose first row is base.
    function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] base_w);
        logic [127:0] o = '0;
        logic [7:0]   base [4];
        for (int k = 0; k < 4; k++) base[k] = base_w[8*k +: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    o[32*c + 8*r +: 8] ^= gmul(base[(k - r + 4) % 4], s[32*c + 8*k +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] ref_inv(input logic [127:0] s);
        return mix(s, {8'd9, 8'd13, 8'd11, 8'd14});
    endfunction

    function automatic logic [127:0] ref_fwd(input logic [127:0] s);
        return mix(s, {8'd1, 8'd1, 8'd3, 8'd2});
    endfunction

    function automatic int iters_of(input int idx);
        return (idx == 0) ? 4 : (idx == 1) ? 2 : 1;
    endfunction

    // Called #1 after a posedge with the instance idle; returns result and accept-to-valid edges.
    task automatic run_xfer(input int idx, input logic [127:0] st,
                            output logic [127:0] res, output int lat);
        in_state_a[idx] = st;
        in_valid_a[idx] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[idx] = 1'b0;
        lat = 0;
        while (!out_valid_a[idx] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_state_a[idx];
        out_ready_a[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[idx] = 1'b0;
    endtask

    logic [127:0] vec0, vec1, res, exp, st;
    int           lat;
    logic         seen;

    initial begin
        vec0 = {32'h01010101, 32'h01010101, 32'h01010101, 32'hbca14d8e};
        vec1 = {4{32'hd6d7d5d5}};
        rst  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i]  = 1'b0;
            in_state_a[i]  = '0;
            out_ready_a[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("reset_in_ready_%0d", i), 128'(in_ready_a[i]), 128'd1);
            check_eq($sformatf("reset_out_valid_%0d", i), 128'(out_valid_a[i]), 128'd0);
            check_eq($sformatf("reset_busy_%0d", i), 128'(busy_a[i]), 128'd0);
            check_eq($sformatf("reset_out_state_%0d", i), out_state_a[i], 128'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        run_xfer(0, vec0, res, lat);
        check_eq("vec0_l1_data", res, {32'h01010101, 32'h01010101, 32'h01010101, 32'h455313db});
        check_eq("vec0_l1_latency", 128'(lat), 128'd4);

        run_xfer(2, vec1, res, lat);
        check_eq("vec1_l4_data", res, {4{32'hd5d4d4d4}});
        check_eq("vec1_l4_latency", 128'(lat), 128'd1);

        run_xfer(1, '0, res, lat);
        check_eq("zero_l2", res, 128'd0);
        check_eq("zero_l2_latency", 128'(lat), 128'd2);
        run_xfer(1, {16{8'hff}}, res, lat);
        check_eq("ones_l2", res, {16{8'hff}});

        // Backpressure in DONE on the LANES=1 instance.
        st  = {$urandom, $urandom, $urandom, $urandom};
        exp = ref_inv(st);
        in_state_a[0] = st;
        in_valid_a[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        lat = 0;
        while (!out_valid_a[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("bp_reach_done", 128'(out_valid_a[0]), 128'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid_a[0] = i[0];
            in_state_a[0] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check_eq("bp_hold_state", out_state_a[0], exp);
            check_eq("bp_in_ready_low", 128'(in_ready_a[0]), 128'd0);
            check_eq("bp_out_valid_held", 128'(out_valid_a[0]), 128'd1);
        end
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[0] = 1'b0;
        check_eq("bp_release_valid", 128'(out_valid_a[0]), 128'd0);
        check_eq("bp_release_ready", 128'(in_ready_a[0]), 128'd1);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen |= out_valid_a[0] | busy_a[0];
        end
        check_eq("bp_no_extra_accept", 128'(seen), 128'd0);

        // Mid-operation reset at col_idx == 2.
        in_state_a[0] = {$urandom, $urandom, $urandom, $urandom};
        in_valid_a[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check_eq("rst_mid_busy_before", 128'(busy_a[0]), 128'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_in_ready", 128'(in_ready_a[0]), 128'd1);
        check_eq("rst_mid_busy", 128'(busy_a[0]), 128'd0);
        check_eq("rst_mid_out_valid", 128'(out_valid_a[0]), 128'd0);
        check_eq("rst_mid_out_state", out_state_a[0], 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen |= out_valid_a[0];
        end
        check_eq("rst_mid_no_valid", 128'(seen), 128'd0);
        run_xfer(0, vec0, res, lat);
        check_eq("rst_mid_reload", res[31:0], 128'h455313db);

        // Round trip through the forward mixer model.
        for (int idx = 0; idx < 3; idx++) begin
            for (int n = 0; n < 1000; n++) begin
                st = {$urandom, $urandom, $urandom, $urandom};
                run_xfer(idx, ref_fwd(st), res, lat);
                check_eq($sformatf("roundtrip_l%0d_%0d", idx, n), res, st);
                if (n == 0) check_eq($sformatf("rt_latency_%0d", idx), 128'(lat),
                                     128'(iters_of(idx)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
